dm_port_arbiter: RTL
====================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the CPU load/store stage and port 1 is the DMA/debug loader.
- The data memory is byte-addressed and big-endian, with a 32-bit word write and a combinational read.
- The block arbitrates, registers the selected transaction, drives the memory's write-enable, address and write-data, and returns registered read data with a per-port ack.
- It sits between the pipeline MEM stage / DMA engine and the data memory.

Parameters:
- DATA_W, 32, data width of requester and memory ports.
- MEM_AW, 10, number of address bits forwarded to the memory; upper address bits are ignored.
- FIXED_PRIO, 0, 0 = round-robin arbitration, 1 = port 0 always wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset; asserted while rst=0.
- req0, req1  in  1  transaction request, held until gnt.
- we0, we1  in  1  1 = word write, 0 = word read.
- addr0, addr1  in  32  byte address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  one-cycle pulse: request accepted; inputs sampled this cycle.
- ack0, ack1  out  1  one-cycle pulse: transaction complete; rdata valid for reads.
- rdata  out  DATA_W  read data, shared by both ports, qualified by ackN.
- mem_we  out  1  to memory MemWrite.
- mem_addr  out  32  to memory Addr; bits above MEM_AW are driven 0.
- mem_wdata  out  DATA_W  to memory Data_in.
- mem_rdata  in  DATA_W  from memory Data_out.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset values (asynchronous, immediate on rst=0): state=IDLE; gnt*, ack*, mem_we and busy are 0; mem_addr, mem_wdata and rdata are 0; round-robin pointer last=1, so port 0 wins first.
- State IDLE:
  - If no request, stay in IDLE.
  - If exactly one request, grant that port.
  - If both request: with FIXED_PRIO=1 grant port 0; otherwise grant the port that is not `last`.
  - On grant: pulse gntN, latch we/addr/wdata into registers, set last=N, go to ACCESS.
- State ACCESS (1 cycle):
  - mem_addr and mem_wdata come from the registers.
  - mem_we = registered we, high for exactly this one cycle.
  - For a read, mem_rdata is captured into rdata at the closing edge.
  - Go to RESP.
- State RESP (1 cycle):
  - Pulse ackN for the owner.
  - rdata holds its value until the next read capture.
  - Arbitration runs here exactly as in IDLE, so a new grant can be issued in the same cycle as the ack.
  - If a grant is issued, go to ACCESS; otherwise go to IDLE.
- Latency and throughput:
  - gnt is issued the cycle req is seen (if the port wins).
  - ack follows gnt by 2 cycles.
  - Sustained throughput is one transaction every 2 cycles.
- Handshake rules:
  - A requester deasserts req, or presents the next request, after gnt.
  - A req still high after gnt is treated as a new request.
  - req dropped before gnt: the transaction is abandoned silently; this is legal.
- gnt0 and gnt1 are never high together; the same holds for ack0 and ack1.
- mem_we is never high outside ACCESS.
- Address: only addr[MEM_AW-1:0] is forwarded; wrap-around of the 4-byte burst is handled by the memory.
- Reset during ACCESS: mem_we drops immediately, the write may be lost, no ack is produced, and the block returns to IDLE.

Optional Feature:
- Macro: DM_ARB_ALIGN_CHK_EN.
- Defined:
  - Adds outputs err0 and err1 (1 bit each, reset 0).
  - A request with addr[1:0]!=0 is still granted.
  - In ACCESS, mem_we is forced to 0.
  - In RESP, errN pulses together with ackN; rdata is unchanged.
- Undefined:
  - No err ports.
  - Misaligned addresses pass through unmodified.

Decomposition:
- Package dm_arb_pkg holds:
  - the state encoding typedef (IDLE, ACCESS, RESP);
  - the DATA_W and MEM_AW default constants;
  - the word-alignment mask constant.
- Sub-module rr_arb2: 2-way round-robin/fixed-priority picker.
  - Inputs: req[1:0], last, fixed_prio.
  - Output: one-hot grant, purely combinational.
- The FSM and datapath registers stay in dm_port_arbiter.

Test Plan:
- Single write: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF.
  - Expect gnt0 at cycle 0, mem_we=1 with mem_addr=0x10 at cycle 1, ack0 at cycle 2.
  - Then read addr0=0x10: expect rdata=0xDEADBEEF with ack0.
- Contention, round-robin: req0 and req1 held high for 4 transactions from reset.
  - Expect grants in order 0,1,0,1, each at 2-cycle spacing.
  - Each ack coincides with the next gnt; there is never a dual gnt.
- FIXED_PRIO=1: both requesting continuously.
  - Expect port 0 to win every time; gnt1 only after req0 drops.
- Reset mid-write: assert rst=0 during ACCESS of a write to 0x20.
  - Expect mem_we=0 immediately, no ack, outputs at reset values.
  - After release, the next req0 is granted.
- Address truncation: write addr1=0xFFFF_F3FC, data 0x01020304.
  - Expect mem_addr=0x3FC; a read of 0x3FC returns 0x01020304.
- With DM_ARB_ALIGN_CHK_EN: write to 0x13.
  - Expect gnt, mem_we stays 0, err0 and ack0 pulse together.
  - A read of 0x10 returns the prior contents.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned DM_DATA_W  = 32;
    localparam int unsigned DM_MEM_AW  = 10;
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & ALIGN_MASK) != '0;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// Two-way request picker: round-robin on `last`, or port 0 always wins when fixed_prio.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (fixed_prio || last) ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one data-memory port between CPU (port 0) and DMA/debug loader (port 1).
// Optional word-alignment check enabled by defining DM_ARB_ALIGN_CHK_EN.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_W     = DM_DATA_W,
    parameter int MEM_AW     = DM_MEM_AW,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DM_ARB_ALIGN_CHK_EN
    ,
    output logic              err0,
    output logic              err1
`endif
);

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                misal_q, misal_d;

    logic [1:0]          pick;
    logic [1:0]          gnt;
    logic                arb_en;
    logic [31:0]         sel_addr;
    logic                blk_mem;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^{addr0[31:MEM_AW], addr1[31:MEM_AW]};

    rr_arb2 u_pick (
        .req       ({req1, req0}),
        .last      (last_q),
        .fixed_prio(FIXED_PRIO != 0),
        .grant     (pick)
    );

    // Gating with rst keeps gnt low for the whole reset interval, not just after the edge.
    assign arb_en   = rst && (state_q == IDLE || state_q == RESP);
    assign gnt      = arb_en ? pick : 2'b00;
    assign sel_addr = gnt[1] ? addr1 : addr0;

`ifdef DM_ARB_ALIGN_CHK_EN
    assign blk_mem = misal_q;
`else
    assign blk_mem = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        misal_d = misal_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (gnt != 2'b00) begin
                    owner_d = gnt[1];
                    last_d  = gnt[1];
                    we_d    = gnt[1] ? we1 : we0;
                    addr_d  = sel_addr[MEM_AW-1:0];
                    wdata_d = gnt[1] ? wdata1 : wdata0;
                    misal_d = is_misaligned(sel_addr);
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!we_q && !blk_mem) rdata_d = mem_rdata;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            misal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            misal_q <= misal_d;
        end
    end

    assign gnt0      = gnt[0];
    assign gnt1      = gnt[1];
    assign ack0      = (state_q == RESP) && !owner_q;
    assign ack1      = (state_q == RESP) && owner_q;
    assign rdata     = rdata_q;
    assign mem_we    = (state_q == ACCESS) && we_q && !blk_mem;
    assign mem_addr  = 32'(addr_q);
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

`ifdef DM_ARB_ALIGN_CHK_EN
    assign err0 = ack0 && misal_q;
    assign err1 = ack1 && misal_q;
`endif

endmodule
